write_ptr: RTL and testbench
============================

// Module: write_ptr
// PURPOSE
//  Write-side pointer/flag controller of the dual-clock FIFO, mirror of the read-side pointer block.
//  - Runs in the write clock domain (clk_i) and keeps the binary write address for the RAM.
//  - Publishes a Gray-coded write pointer to the read domain.
//  - Synchronises the read domain's Gray pointer (2-flop) and derives full, almost-full, fill level and a sticky overflow flag.
// PARAMETERS
//  ADDR_SIZE  8  RAM address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits; legal range >= 2
//  AF_THRESH  2**ADDR_SIZE-4  almost_full_o asserts when level_o >= AF_THRESH; legal 1..2**ADDR_SIZE
// PORTS
//  clk_i          in   1             write-domain clock
//  rst_i          in   1             asynchronous, active-low reset
//  rd_ptr_i       in   ADDR_SIZE+1   Gray read pointer from read domain (unsynchronised)
//  inc_i          in   1             write request; accepted only when !full_o
//  clr_ovf_i      in   1             clears overflow_o
//  ptr_o          out  ADDR_SIZE+1   registered Gray write pointer, to read-domain synchroniser
//  addr_o         out  ADDR_SIZE     RAM write address = bin_cnt[ADDR_SIZE-1:0]
//  we_o           out  1             RAM write enable = inc_i & !full_o (combinational)
//  fifo_full_o    out  1             FIFO full
//  almost_full_o  out  1             level_o >= AF_THRESH
//  level_o        out  ADDR_SIZE+1   words stored, as seen from write domain (0..2**ADDR_SIZE)
//  overflow_o     out  1             sticky: write attempted while full
// BEHAVIOUR
//  - Reset (rst_i low, async): bin_cnt, gray_cnt, rq1, rq2, overflow <= 0.
//    - Outputs during reset: ptr_o=0, addr_o=0, fifo_full_o=0, almost_full_o=(AF_THRESH==0 ? 1 : 0), level_o=0, overflow_o=0.
//    - Release is synchronous to the next clk_i edge.
//  - Synchroniser: rq1 <= rd_ptr_i; rq2 <= rq1.
//    - A read-pointer change is visible to the flags 2 clk_i edges later.
//    - No logic is placed between rd_ptr_i and rq1.
//  - Increment: bin_n = bin_cnt + (inc_i & !fifo_full_o); gray_n = (bin_n>>1) ^ bin_n.
//    - Both are registered every edge; ptr_o is driven straight from the gray register (glitch-free).
//  - Full: fifo_full_o = (gray_cnt == {~rq2[ADDR_SIZE:ADDR_SIZE-1], rq2[ADDR_SIZE-2:0]}).
//    - Combinational from registers only; it never depends on inc_i.
//  - Write acceptance: we_o and the address increment share the same condition and cycle.
//    - The RAM writes data at addr_o on the edge where we_o=1.
//    - Write latency 0: the pointer advances on that same edge.
//  - Level: rbin = gray-to-binary(rq2); level_o = bin_cnt - rbin, modulo 2**(ADDR_SIZE+1).
//    - Equals 2**ADDR_SIZE exactly when full.
//    - Pessimistic: the read side may have drained more than level_o shows.
//  - Overflow: set on any edge where inc_i & fifo_full_o.
//    - Cleared on an edge with clr_ovf_i & !(inc_i & fifo_full_o); set wins over a simultaneous clear.
//    - A rejected write changes no pointer.
//  - Wrap-around: pointers roll over at 2**(ADDR_SIZE+1) with no special case.
//    - The MSB difference distinguishes full from empty.
//  - Full deassertion: occurs 2 edges after the read-side pointer advances.
//    - Full assertion: immediate, on the edge of the last accepted write.
//  - Reset mid-operation: all state returns to 0 immediately.
//    - The read domain must be reset together with this block; otherwise the flags are undefined.
// TESTING  (ADDR_SIZE=4, AF_THRESH=12)
//  1 Reset: assert rst_i low between edges -> all outputs 0 at once; hold rd_ptr_i=0 and release -> level_o=0, fifo_full_o=0.
//  2 Fill: 16 cycles inc_i=1, rd_ptr_i=0 -> we_o high 16 cycles; after the 16th edge fifo_full_o=1, ptr_o=5'b11000, level_o=16.
//    - almost_full_o first goes high after the 12th write.
//  3 Overflow: with full, inc_i=1 -> we_o=0, ptr_o/addr_o unchanged, overflow_o=1.
//    - Pulse clr_ovf_i with inc_i=1 -> overflow_o stays 1; with inc_i=0 -> overflow_o clears.
//  4 Drain sync: while full, drive rd_ptr_i=5'b00001 (gray 1) -> fifo_full_o stays 1 for 2 edges, then drops with level_o=15.
//  5 Wrap: step rd_ptr_i to keep the FIFO near-empty while writing 40 words -> addr_o wraps 15->0.
//    - bin_cnt wraps 31->0; full is never asserted falsely; level_o stays correct across the wrap.
//  6 Reset mid-fill: after 7 writes assert rst_i -> ptr_o=0, level_o=0, overflow_o=0; the next write uses addr_o=0.

Source files
------------

// File: rtl/write_ptr.sv
// Write-side pointer and flag controller of a dual-clock FIFO.
// Owns the binary/Gray write pointer and derives full, almost-full, level and overflow from the synchronised read pointer.
module write_ptr #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned AF_THRESH = 2**ADDR_SIZE - 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_SIZE:0]   rd_ptr_i,
  input  logic                 inc_i,
  input  logic                 clr_ovf_i,
  output logic [ADDR_SIZE:0]   ptr_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic                 we_o,
  output logic                 fifo_full_o,
  output logic                 almost_full_o,
  output logic [ADDR_SIZE:0]   level_o,
  output logic                 overflow_o
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [PW-1:0] r_bin_cnt;
  logic [PW-1:0] r_gray_cnt;
  logic [PW-1:0] r_rq1;
  logic [PW-1:0] r_rq2;
  logic          r_overflow;

  logic [PW-1:0] w_bin_n;
  logic [PW-1:0] w_gray_n;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_cmp;
  logic          w_full;
  logic          w_accept;
  logic          w_reject;
  logic [PW-1:0] w_level;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign w_full_cmp = {~r_rq2[ADDR_SIZE:ADDR_SIZE-1], r_rq2[ADDR_SIZE-2:0]};
  assign w_full     = (r_gray_cnt == w_full_cmp);
  assign w_accept   = inc_i & ~w_full;
  assign w_reject   = inc_i & w_full;

  assign w_bin_n  = r_bin_cnt + PW'(w_accept);
  assign w_gray_n = (w_bin_n >> 1) ^ w_bin_n;

  // Level uses the stale read pointer, so it can only over-report occupancy.
  assign w_rbin  = gray2bin(r_rq2);
  assign w_level = r_bin_cnt - w_rbin;

  // Pointer state, two-flop read-pointer synchroniser and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bin_cnt  <= '0;
      r_gray_cnt <= '0;
      r_rq1      <= '0;
      r_rq2      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_bin_cnt  <= w_bin_n;
      r_gray_cnt <= w_gray_n;
      r_rq1      <= rd_ptr_i;
      r_rq2      <= r_rq1;
      if (w_reject) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ptr_o         = r_gray_cnt;
  assign addr_o        = r_bin_cnt[ADDR_SIZE-1:0];
  assign we_o          = w_accept;
  assign fifo_full_o   = w_full;
  assign level_o       = w_level;
  assign almost_full_o = (w_level >= AF_LVL);
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_write_ptr.sv
// Bench for write_ptr (ADDR_SIZE=4, AF_THRESH=12): directed table, reset corners and random traffic
// checked against an occupancy-count model of the FIFO write side.
module tb_write_ptr;

  localparam int unsigned AS  = 4;
  localparam int unsigned AFT = 12;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;

  logic          clk_i;
  logic          rst_i;
  logic [AS:0]   rd_ptr_i;
  logic          inc_i;
  logic          clr_ovf_i;
  logic [AS:0]   ptr_o;
  logic [AS-1:0] addr_o;
  logic          we_o;
  logic          fifo_full_o;
  logic          almost_full_o;
  logic [AS:0]   level_o;
  logic          overflow_o;

  write_ptr #(.ADDR_SIZE(AS), .AF_THRESH(AFT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rd_ptr_i(rd_ptr_i), .inc_i(inc_i),
    .clr_ovf_i(clr_ovf_i), .ptr_o(ptr_o), .addr_o(addr_o), .we_o(we_o),
    .fifo_full_o(fifo_full_o), .almost_full_o(almost_full_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;

  // Model: counts of words written and read seen by the write side, two-edge read visibility.
  int m_wr, m_seen, m_q1, m_ovf;
  int rd_bin;

  typedef struct {
    bit inc; bit clr; int rd;
    int we; int full; int af; int level; int ovf; int addr; int ptr;
  } vec_t;
  vec_t tbl[$];

  function automatic int gray(input int x);
    return (x ^ (x >> 1)) & (MOD - 1);
  endfunction

  function automatic int m_level();
    return (m_wr - m_seen + MOD) % MOD;
  endfunction

  function automatic int m_full();
    return (m_level() == DEPTH) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_seen = 0; m_q1 = 0; m_ovf = 0; rd_bin = 0;
  endtask

  task automatic model_edge(input bit inc, input bit clr, input int rd);
    int f;
    f = m_full();
    if (inc && f == 1) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (inc && f == 0) m_wr = (m_wr + 1) % MOD;
    m_seen = m_q1;
    m_q1 = rd;
  endtask

  task automatic drive(input bit inc, input bit clr, input int rd);
    @(negedge clk_i);
    inc_i = inc; clr_ovf_i = clr; rd_ptr_i = (AS+1)'(gray(rd));
    #1;
  endtask

  task automatic edge_step(input bit inc, input bit clr, input int rd);
    @(posedge clk_i);
    model_edge(inc, clr, rd);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ptr"},   int'(ptr_o), gray(m_wr));
    chk({tag, ".addr"},  int'(addr_o), m_wr % DEPTH);
    chk({tag, ".full"},  int'(fifo_full_o), m_full());
    chk({tag, ".af"},    int'(almost_full_o), (m_level() >= AFT) ? 1 : 0);
    chk({tag, ".level"}, int'(level_o), m_level());
    chk({tag, ".ovf"},   int'(overflow_o), m_ovf);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ptr"},   int'(ptr_o), 0);
    chk({tag, ".addr"},  int'(addr_o), 0);
    chk({tag, ".full"},  int'(fifo_full_o), 0);
    chk({tag, ".af"},    int'(almost_full_o), 0);
    chk({tag, ".level"}, int'(level_o), 0);
    chk({tag, ".ovf"},   int'(overflow_o), 0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b0; inc_i = 1'b0; clr_ovf_i = 1'b0; rd_ptr_i = '0;
    #1;
    chk_zero(tag);
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic push_vec(input bit inc, input bit clr, input int rd, input int we,
                          input int full, input int af, input int level, input int ovf,
                          input int addr, input int ptr);
    vec_t v;
    v.inc = inc; v.clr = clr; v.rd = rd; v.we = we; v.full = full; v.af = af;
    v.level = level; v.ovf = ovf; v.addr = addr; v.ptr = ptr;
    tbl.push_back(v);
  endtask

  initial begin
    int pinc, prd;
    rst_i = 1'b0; inc_i = 1'b0; clr_ovf_i = 1'b0; rd_ptr_i = '0;
    model_reset();

    // Expected values for fill, overflow and drain, written from the FIFO's intended behaviour.
    for (int i = 0; i < 16; i++)
      push_vec(1, 0, 0, 1, (i == 15) ? 1 : 0, (i + 1 >= 12) ? 1 : 0, i + 1, 0,
               (i + 1) % 16, (i + 1) ^ ((i + 1) >> 1));
    push_vec(1, 0, 0, 0, 1, 1, 16, 1, 0, 24);
    push_vec(1, 1, 0, 0, 1, 1, 16, 1, 0, 24);
    push_vec(0, 1, 0, 0, 1, 1, 16, 0, 0, 24);
    push_vec(0, 0, 1, 0, 1, 1, 16, 0, 0, 24);
    push_vec(0, 0, 1, 0, 0, 1, 15, 0, 0, 24);
    push_vec(1, 0, 1, 1, 1, 1, 16, 0, 1, 25);

    // Reset state after power-up, then a mid-stream async reset.
    #2;
    chk_zero("por");
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk_model("rel");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      edge_step(1, 0, 0);
    end
    chk("pre_rst.level", int'(level_o), 3);
    do_reset("rst1");
    chk_model("rst1_rel");

    foreach (tbl[k]) begin
      drive(tbl[k].inc, tbl[k].clr, tbl[k].rd);
      chk($sformatf("tbl%0d.we", k), int'(we_o), tbl[k].we);
      edge_step(tbl[k].inc, tbl[k].clr, tbl[k].rd);
      chk($sformatf("tbl%0d.full", k),  int'(fifo_full_o), tbl[k].full);
      chk($sformatf("tbl%0d.af", k),    int'(almost_full_o), tbl[k].af);
      chk($sformatf("tbl%0d.level", k), int'(level_o), tbl[k].level);
      chk($sformatf("tbl%0d.ovf", k),   int'(overflow_o), tbl[k].ovf);
      chk($sformatf("tbl%0d.addr", k),  int'(addr_o), tbl[k].addr);
      chk($sformatf("tbl%0d.ptr", k),   int'(ptr_o), tbl[k].ptr);
    end

    // Reset after 7 writes; the next accepted write must target address 0.
    do_reset("rst2a");
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0);
      edge_step(1, 0, 0);
    end
    chk("mid.addr", int'(addr_o), 7);
    do_reset("rst2");
    drive(1, 0, 0);
    chk("post_rst.we", int'(we_o), 1);
    chk("post_rst.addr", int'(addr_o), 0);
    edge_step(1, 0, 0);
    chk_model("post_rst");

    // Random traffic: near-empty phase exercises wrap, then write-heavy phase exercises full/overflow.
    do_reset("rst3");
    for (int ph = 0; ph < 2; ph++) begin
      pinc = (ph == 0) ? 70 : 90;
      prd  = (ph == 0) ? 85 : 30;
      for (int c = 0; c < 150; c++) begin
        bit inc, clr;
        inc = ($urandom_range(0, 99) < pinc);
        clr = ($urandom_range(0, 99) < 10);
        if (((m_wr - rd_bin + MOD) % MOD) > 0 && $urandom_range(0, 99) < prd)
          rd_bin = (rd_bin + 1) % MOD;
        drive(inc, clr, rd_bin);
        chk("rnd.we", int'(we_o), (inc && m_full() == 0) ? 1 : 0);
        edge_step(inc, clr, rd_bin);
        chk_model("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
